// File: rtl/logip_core_if.sv
// Pin bundle for the logic-analyzer core: probe channels in, host UART rx in, UART tx out.
// Latency/backpressure: plain wires, none.
`timescale 1ns/1ps
interface logip_core_if;
    logic [31:0] chls_i;
    logic        rx_i;
    logic        tx_o;

    modport master (output chls_i, output rx_i, input tx_o);
    modport slave  (input chls_i, input rx_i, output tx_o);
endinterface

// File: rtl/logip_core.sv
// SUMP-style 32-channel logic analyzer: UART command parser, strobed ring-buffer capture, trigger, dump.
// Latency: chls to sample 2 cycles, reply start <=2 cycles; no backpressure (host must accept the UART stream).
`timescale 1ns/1ps
module logip_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    logip_core_if.slave pins
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(CLKS_PER_BIT);
    localparam logic [KW-1:0] BIT_LAST = KW'(CLKS_PER_BIT - 1);
    localparam logic [KW-1:0] BIT_HALF = KW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_DUMP} st_e;

    logic [31:0]   chls_m_q, chls_s_q;
    logic          rx_m_q, rx_s_q;

    rx_st_e        rx_st_q, rx_st_d;
    logic [KW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d;

    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic [KW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_left_q, tx_left_d;
    logic [8:0]    tx_sh_q, tx_sh_d;

    logic [2:0]    argn_q, argn_d;
    logic [7:0]    op_q, op_d;
    logic [31:0]   arg_q, arg_d;

    st_e           state_q, state_d;
    logic [31:0]   mask_q, mask_d, value_q, value_d, flags_q, flags_d;
    logic [23:0]   div_q, div_d, divc_q, divc_d;
    logic [CW-1:0] rdcnt_q, rdcnt_d, dlcnt_q, dlcnt_d;
    logic [CW-1:0] del_q, del_d, left_q, left_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    byte_q, byte_d;
    logic          id_busy_q, id_busy_d;
    logic [1:0]    id_idx_q, id_idx_d;

    logic [31:0]   mem_q [DEPTH];

    logic          short_vld, long_vld;
    logic [31:0]   arg_full;
    logic          cmd_reset, cmd_arm, cmd_id, cfg_vld;
    logic [18:0]   rc_raw, dc_raw;
    logic          sampling, strobe, hit;
    logic          tx_go, dump_acc;
    logic [7:0]    tx_byte, id_byte;
    logic [31:0]   rd_word;
    logic          unused_flags;

    // Flags are accepted for host-protocol compatibility but change nothing here.
    assign unused_flags = ^flags_q;
    assign pins.tx_o    = tx_q;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_vld_d = 1'b0;
        case (rx_st_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s_q) rx_st_d = R_START;
            end
            R_START: if (rx_cnt_q == BIT_HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
            end
            R_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_vld_d = rx_s_q;
                rx_st_d  = R_IDLE;
            end
            default: rx_st_d = R_IDLE;
        endcase
    end

    always_comb begin
        short_vld = 1'b0;
        long_vld  = 1'b0;
        argn_d    = argn_q;
        op_d      = op_q;
        arg_d     = arg_q;
        arg_full  = {rx_sh_q, arg_q[31:8]};
        if (rx_vld_q) begin
            if (argn_q == 3'd0) begin
                if (rx_sh_q[7]) begin
                    op_d   = rx_sh_q;
                    argn_d = 3'd1;
                end else begin
                    short_vld = 1'b1;
                end
            end else begin
                arg_d = arg_full;
                if (argn_q == 3'd4) begin
                    argn_d   = 3'd0;
                    long_vld = 1'b1;
                end else begin
                    argn_d = argn_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cmd_reset = short_vld && (rx_sh_q == 8'h00) && (state_q != S_DUMP);
        cmd_arm   = short_vld && (rx_sh_q == 8'h01) && (state_q == S_IDLE);
        cmd_id    = short_vld && (rx_sh_q == 8'h02) && (state_q == S_IDLE) && !id_busy_q;
        cfg_vld   = long_vld && (state_q == S_IDLE);
        rc_raw    = ({3'b000, arg_full[15:0]}  + 19'd1) << 2;
        dc_raw    = ({3'b000, arg_full[31:16]} + 19'd1) << 2;
        sampling  = (state_q == S_ARMED) || (state_q == S_DELAY);
        strobe    = sampling && (divc_q == div_q);
        hit       = ((chls_s_q ^ value_q) & mask_q) == 32'h0;
        rd_word   = mem_q[rd_ptr_q];
        case (id_idx_q)
            2'd0:    id_byte = 8'h31;
            2'd1:    id_byte = 8'h41;
            2'd2:    id_byte = 8'h4C;
            default: id_byte = 8'h53;
        endcase
        tx_byte  = id_busy_q ? id_byte : rd_word[{byte_q, 3'b000} +: 8];
        tx_go    = (id_busy_q || (state_q == S_DUMP)) && !tx_busy_q;
        dump_acc = tx_go && !id_busy_q && (state_q == S_DUMP);
    end

    always_comb begin
        mask_d    = mask_q;
        value_d   = value_q;
        flags_d   = flags_q;
        div_d     = div_q;
        rdcnt_d   = rdcnt_q;
        dlcnt_d   = dlcnt_q;
        state_d   = state_q;
        del_d     = del_q;
        left_d    = left_q;
        rd_ptr_d  = rd_ptr_q;
        byte_d    = byte_q;
        id_busy_d = id_busy_q;
        id_idx_d  = id_idx_q;
        wr_ptr_d  = strobe ? wr_ptr_q + 1'b1 : wr_ptr_q;
        divc_d    = divc_q;
        if (cmd_arm)       divc_d = '0;
        else if (sampling) divc_d = strobe ? 24'h0 : divc_q + 1'b1;

        if (cfg_vld) begin
            case (op_q)
                8'hC0: mask_d  = arg_full;
                8'hC1: value_d = arg_full;
                8'h80: div_d   = arg_full[23:0];
                8'h81: begin
                    rdcnt_d = (rc_raw > 19'(DEPTH)) ? DEPTH_C : rc_raw[CW-1:0];
                    dlcnt_d = (dc_raw > 19'(DEPTH)) ? DEPTH_C : dc_raw[CW-1:0];
                end
                8'h82: flags_d = arg_full;
                default: ;
            endcase
        end

        if (cmd_id) begin
            id_busy_d = 1'b1;
            id_idx_d  = 2'd0;
        end else if (id_busy_q && tx_go) begin
            id_idx_d = id_idx_q + 1'b1;
            if (id_idx_q == 2'd3) id_busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: if (cmd_arm) state_d = S_ARMED;
            S_ARMED: begin
                if (cmd_reset) begin
                    state_d = S_IDLE;
                end else if (strobe && hit) begin
                    del_d = '0;
                    // A zero post-trigger delay dumps straight from the trigger sample.
                    if (dlcnt_q == '0) begin
                        state_d  = S_DUMP;
                        rd_ptr_d = wr_ptr_q;
                        left_d   = rdcnt_q;
                        byte_d   = 2'd0;
                    end else begin
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (cmd_reset) begin
                    state_d = S_IDLE;
                end else if (strobe) begin
                    del_d = del_q + 1'b1;
                    if (del_q == dlcnt_q - 1'b1) begin
                        state_d  = S_DUMP;
                        rd_ptr_d = wr_ptr_q;
                        left_d   = rdcnt_q;
                        byte_d   = 2'd0;
                    end
                end
            end
            S_DUMP: if (dump_acc) begin
                byte_d = byte_q + 1'b1;
                if (byte_q == 2'd3) begin
                    rd_ptr_d = rd_ptr_q - 1'b1;
                    left_d   = left_q - 1'b1;
                    if (left_q == CW'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d      = tx_q;
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q + 1'b1;
        tx_left_d = tx_left_q;
        tx_sh_d   = tx_sh_q;
        if (!tx_busy_q) begin
            tx_cnt_d = '0;
            if (tx_go) begin
                tx_busy_d = 1'b1;
                tx_d      = 1'b0;
                tx_sh_d   = {1'b1, tx_byte};
                tx_left_d = 4'd9;
            end
        end else if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (tx_left_q == 4'd0) begin
                tx_busy_d = 1'b0;
            end else begin
                tx_d      = tx_sh_q[0];
                tx_sh_d   = {1'b1, tx_sh_q[8:1]};
                tx_left_d = tx_left_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (strobe) mem_q[wr_ptr_q] <= chls_s_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chls_m_q  <= '0;
            chls_s_q  <= '0;
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_st_q   <= R_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_vld_q  <= 1'b0;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_left_q <= '0;
            tx_sh_q   <= '1;
            argn_q    <= '0;
            op_q      <= '0;
            arg_q     <= '0;
            state_q   <= S_IDLE;
            mask_q    <= '0;
            value_q   <= '0;
            flags_q   <= '0;
            div_q     <= '0;
            divc_q    <= '0;
            rdcnt_q   <= DEPTH_C;
            dlcnt_q   <= '0;
            del_q     <= '0;
            left_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            byte_q    <= '0;
            id_busy_q <= 1'b0;
            id_idx_q  <= '0;
        end else begin
            chls_m_q  <= pins.chls_i;
            chls_s_q  <= chls_m_q;
            rx_m_q    <= pins.rx_i;
            rx_s_q    <= rx_m_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_vld_q  <= rx_vld_d;
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_left_q <= tx_left_d;
            tx_sh_q   <= tx_sh_d;
            argn_q    <= argn_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            state_q   <= state_d;
            mask_q    <= mask_d;
            value_q   <= value_d;
            flags_q   <= flags_d;
            div_q     <= div_d;
            divc_q    <= divc_d;
            rdcnt_q   <= rdcnt_d;
            dlcnt_q   <= dlcnt_d;
            del_q     <= del_d;
            left_q    <= left_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            byte_q    <= byte_d;
            id_busy_q <= id_busy_d;
            id_idx_q  <= id_idx_d;
        end
    end
endmodule

// File: tb/tb_logip_core.sv
// Directed bench for logip_core: drives host UART bytes, decodes the UART reply stream into a queue.
`timescale 1ns/1ps
module tb_logip_core;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cnt_en = 1'b0;
    logic [31:0] chls_fix = 32'h0;
    logic [31:0] free_cnt = 32'h0;
    logic [7:0]  mon_b;
    logic [7:0]  txq[$];
    int          checks = 0;
    int          errors = 0;

    logip_core_if bus ();

    logip_core #(.CLKS_PER_BIT(CPB), .DEPTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pins  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        free_cnt   = free_cnt + 1;
        bus.chls_i = cnt_en ? free_cnt : chls_fix;
    end

    // UART decoder on tx_o, sampling mid-bit on falling clock edges.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_o === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = bus.tx_o;
                end
                repeat (CPB) @(negedge clk);
                checks++;
                assert (bus.tx_o === 1'b1) else begin
                    errors++;
                    $error("FAIL tx_stop_bit: observed %b expected 1", bus.tx_o);
                end
                txq.push_back(mon_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx_i = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_long(input logic [7:0] op, input logic [31:0] arg);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(arg[8*i +: 8]);
    endtask

    task automatic get_byte(output logic [7:0] b);
        int n;
        n = 0;
        while (txq.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (txq.size() != 0) else begin
            errors++;
            $error("FAIL tx_byte_timeout: observed no byte after %0d cycles, expected one", n);
        end
        if (txq.size() != 0) b = txq.pop_front();
        else                 b = 8'h00;
    endtask

    task automatic get_word(output logic [31:0] w);
        logic [7:0] b;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            get_byte(b);
            w[8*i +: 8] = b;
        end
    endtask

    task automatic expect_id(input string tag);
        logic [7:0]  b;
        logic [31:0] ids;
        ids = 32'h534C4131;
        for (int i = 0; i < 4; i++) begin
            get_byte(b);
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, b}, {24'h0, ids[8*i +: 8]});
        end
    endtask

    task automatic expect_step(input string tag, input logic [31:0] step);
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) get_word(w[i]);
        for (int i = 1; i < 4; i++)
            chk($sformatf("%s_%0d", tag, i), w[i], w[i-1] - step);
    endtask

    initial begin
        logic        seen;
        logic [31:0] w;
        logic [31:0] trig_exp [8];
        trig_exp = '{32'h55, 32'h55, 32'h55, 32'h55, 32'h55, 32'h0, 32'h0, 32'h0};

        rst      = 1'b1;
        bus.rx_i = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("reset_tx_idle", {31'h0, bus.tx_o}, 32'h1);

        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (bus.tx_o !== 1'b1) seen = 1'b1;
        end
        chk("idle_no_start_bit", {31'h0, seen}, 32'h0);
        chk("idle_no_bytes", txq.size(), 32'h0);

        send_byte(8'h02);
        expect_id("id");

        // Free-running counter, trigger on the first sample, read 4 / delay 4.
        cnt_en = 1'b1;
        send_long(8'h81, 32'h0);
        send_byte(8'h01);
        expect_step("count_div0", 32'd1);

        send_long(8'h80, 32'h3);
        send_byte(8'h01);
        expect_step("count_div3", 32'd4);

        cnt_en   = 1'b0;
        chls_fix = 32'h0;
        send_long(8'hC0, 32'h000000FF);
        send_long(8'hC1, 32'h00000055);
        send_long(8'h81, 32'h00000001);
        send_byte(8'h01);
        repeat (20) @(negedge clk);
        chls_fix = 32'h55;
        for (int i = 0; i < 8; i++) begin
            get_word(w);
            chk($sformatf("trig_sample%0d", i), w, trig_exp[i]);
        end

        chls_fix = 32'h0;
        send_long(8'hC0, 32'hFFFFFFFF);
        send_long(8'hC1, 32'h00000001);
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (300) @(negedge clk);
        chk("abort_no_tx", txq.size(), 32'h0);
        send_byte(8'h02);
        expect_id("id_after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
